pulse_correlator_core: RTL and testbench
========================================

// Module: pulse_correlator_core
// PURPOSE
// Parametrised multi-lag pulse correlator core, next generation of the fixed zero-lag correlator.
// - Samples NUM_INPUTS pulse lines at a divided rate, applies per-input polarity, and counts per-input ones.
// - Counts pairwise coincidences at lags -MAX_DELAY..+MAX_DELAY over an integration window.
// - At the end of each window, double-buffers the results and streams them out over a valid/ready port to the UART framer.
// PARAMETERS
// NUM_INPUTS     4       number of pulse inputs (>=2)
// RESOLUTION     16      accumulator and out_data width, in bits
// MAX_DELAY      1       max lag magnitude in samples (>=0)
// SAMPLE_DIV     25      clki cycles per sample tick (>=2)
// INTEG_SAMPLES  1000    sample ticks per integration window (>=1)
// INVERT_MASK    all 1s  bit k=1 inverts pulse_in[k] after synchronisation
// Derived: NUM_PAIRS=NUM_INPUTS*(NUM_INPUTS-1)/2; NUM_LAGS=2*MAX_DELAY+1; FRAME_WORDS=NUM_INPUTS+NUM_PAIRS*NUM_LAGS
// PORTS
// clki                   in   1             system clock, all logic on rising edge
// rstn                   in   1             synchronous active-low reset
// enable                 in   1             0: dividers, sample counter and accumulators frozen
// pulse_in               in   NUM_INPUTS    asynchronous pulse lines
// sample_clk_pulse       out  1             1-cycle strobe per sample tick
// integration_clk_pulse  out  1             1-cycle strobe when a frame is captured
// out_data               out  RESOLUTION    frame word
// out_valid              out  1             out_data valid
// out_ready              in   1             sink accepts the word when out_valid&out_ready
// out_last               out  1             marks the final word of a frame
// overrun                out  1             1-cycle strobe: a frame was dropped
// BEHAVIOUR
// - Reset (rstn=0 at an edge): all outputs 0; dividers, counters, delay lines, accumulators and shadow buffer cleared.
//   A frame in progress is discarded, with no out_last.
// - Input path: 2-FF synchroniser, then XOR with INVERT_MASK, giving x.
// - Divider: div counts 0..SAMPLE_DIV-1 while enable=1. When div==SAMPLE_DIV-1, tick=1 and sample_clk_pulse=1 in the next cycle.
// - On tick: s[k][0]<=x[k]; s[k][m]<=s[k][m-1] for m=1..MAX_DELAY. The history is zero after reset.
// - Accumulate in the cycle after tick (the sample_clk_pulse cycle):
//   - A[k] += s[k][0];
//   - C[i,j,L] += s[i][0]&s[j][L] for L>=0;
//   - C[i,j,L] += s[i][-L]&s[j][0] for L<0;
//   - for all i<j.
// - Saturation: accumulators saturate at 2^RESOLUTION-1 and never wrap.
// - Window: scnt counts accumulate cycles. On the INTEG_SAMPLES-th:
//   - shadow <= A/C including this sample's contribution;
//   - A/C <= 0;
//   - scnt <= 0.
//   integration_clk_pulse=1 in the next cycle.
// - Readout FSM:
//   - IDLE -> SEND when a frame is captured. out_valid rises in the same cycle as integration_clk_pulse.
//   - SEND: word order is A[0..N-1], then pairs (0,1),(0,2)..(N-2,N-1) lexicographic, each with lag -MAX_DELAY..+MAX_DELAY.
//   - Index advances only on out_valid&out_ready. out_data/out_valid hold stable while out_ready=0.
//   - out_last=1 on word FRAME_WORDS-1. Acceptance of that word -> IDLE, with out_valid=0 in the next cycle.
// - Overrun: a capture while in SEND, or on the same edge the last word is accepted, keeps the shadow unchanged and pulses overrun.
//   Integration still clears and restarts. integration_clk_pulse still fires.
// - enable=0: div, scnt and accumulators hold; no ticks occur; readout continues. Deasserting enable mid-window does not truncate the window.
// - MAX_DELAY=0: no delay registers; NUM_LAGS=1 (zero lag only).
// TESTING (bench params: NUM_INPUTS=3, MAX_DELAY=1, SAMPLE_DIV=4, INTEG_SAMPLES=8, INVERT_MASK=0, RESOLUTION=8; FRAME_WORDS=12)
// 1 All inputs held 1, out_ready=1 -> sample_clk_pulse every 4 cycles; integration_clk_pulse every 32 cycles;
//   frame 1 = A=8,8,8; each pair lags -1,0,+1 = 7,8,7; out_last on word 12.
// 2 pulse_in[0]=1 on sample 3 only, pulse_in[1]=1 on sample 4 only, input 2=0 -> A=1,1,0;
//   pair(0,1) lags -1,0,+1 = 1,0,0; all other words 0.
// 3 out_ready=0 for 10 cycles mid-frame -> out_data/out_valid stable, no word skipped or repeated;
//   out_ready held 0 through the next capture -> overrun pulses once and resumed readout shows the old frame.
// 4 INVERT_MASK=3'b111, pulse_in held 0 -> same frame as scenario 1.
// 5 RESOLUTION=3, all inputs 1 -> all counts saturate at 7, no wrap.
// 6 rstn=0 for 1 cycle at word 5 of a frame -> next cycle all outputs 0; next frame starts 32 cycles after release with word 0.
//   enable=0 for 20 cycles mid-window -> window lengthened by exactly 20 cycles.

Source files
------------

// File: rtl/pulse_correlator_core.sv
// pulse_correlator_core: multi-lag pulse correlator with saturating window accumulators and double-buffered valid/ready frame readout
module pulse_correlator_core #(
  parameter int NUM_INPUTS = 4,
  parameter int RESOLUTION = 16,
  parameter int MAX_DELAY = 1,
  parameter int SAMPLE_DIV = 25,
  parameter int INTEG_SAMPLES = 1000,
  parameter logic [NUM_INPUTS-1:0] INVERT_MASK = '1
) (
  input  logic                  clki,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [NUM_INPUTS-1:0] pulse_in,
  output logic                  sample_clk_pulse,
  output logic                  integration_clk_pulse,
  output logic [RESOLUTION-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  overrun
);
  localparam int NUM_PAIRS = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
  localparam int NUM_LAGS = 2 * MAX_DELAY + 1;
  localparam int FRAME_WORDS = NUM_INPUTS + NUM_PAIRS * NUM_LAGS;
  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int SW = $clog2(INTEG_SAMPLES + 1);
  localparam int IW = $clog2(FRAME_WORDS);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'(INTEG_SAMPLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_WORDS - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic [NUM_INPUTS-1:0] sync1, sync2, x;
  logic [NUM_INPUTS-1:0] s [MAX_DELAY+1];
  logic [DW-1:0] div;
  logic [SW-1:0] scnt;
  logic [IW-1:0] idx, idx_nxt;
  logic [RESOLUTION-1:0] acc [FRAME_WORDS];
  logic [RESOLUTION-1:0] acc_next [FRAME_WORDS];
  logic [RESOLUTION-1:0] shadow [FRAME_WORDS];
  logic [FRAME_WORDS-1:0] inc;
  logic tick, cap;
  assign x = sync2 ^ INVERT_MASK;
  assign tick = enable && div == DIV_LAST;
  assign cap = sample_clk_pulse && scnt == SCNT_LAST;
  assign idx_nxt = idx + IW'(1);
  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_ones
    assign inc[k] = s[0][k];
  end
  for (genvar i = 0; i < NUM_INPUTS - 1; i++) begin : g_i
    for (genvar j = i + 1; j < NUM_INPUTS; j++) begin : g_j
      for (genvar l = 0; l < NUM_LAGS; l++) begin : g_l
        localparam int W = NUM_INPUTS + (i * NUM_INPUTS - i * (i + 1) / 2 + j - i - 1) * NUM_LAGS + l;
        if (l >= MAX_DELAY) begin : g_pos
          assign inc[W] = s[0][i] & s[l-MAX_DELAY][j];
        end else begin : g_neg
          assign inc[W] = s[MAX_DELAY-l][i] & s[0][j];
        end
      end
    end
  end
  always_comb begin
    for (int w = 0; w < FRAME_WORDS; w++)
      acc_next[w] = (&acc[w]) ? acc[w] : acc[w] + RESOLUTION'(inc[w]);
  end
  always_ff @(posedge clki) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      div <= '0;
      scnt <= '0;
      idx <= '0;
      state <= IDLE;
      sample_clk_pulse <= 1'b0;
      integration_clk_pulse <= 1'b0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      overrun <= 1'b0;
      for (int m = 0; m <= MAX_DELAY; m++) s[m] <= '0;
      for (int w = 0; w < FRAME_WORDS; w++) begin
        acc[w] <= '0;
        shadow[w] <= '0;
      end
    end else begin
      sync1 <= pulse_in;
      sync2 <= sync1;
      sample_clk_pulse <= tick;
      integration_clk_pulse <= cap;
      overrun <= cap && state == SEND;
      if (enable) div <= tick ? '0 : div + DW'(1);
      if (tick) begin
        s[0] <= x;
        for (int m = 1; m <= MAX_DELAY; m++) s[m] <= s[m-1];
      end
      if (sample_clk_pulse) begin
        scnt <= cap ? '0 : scnt + SW'(1);
        for (int w = 0; w < FRAME_WORDS; w++) acc[w] <= cap ? '0 : acc_next[w];
      end
      if (state == IDLE) begin
        if (cap) begin
          state <= SEND;
          idx <= '0;
          out_valid <= 1'b1;
          out_last <= 1'b0;
          out_data <= acc_next[0];
          for (int w = 0; w < FRAME_WORDS; w++) shadow[w] <= acc_next[w];
        end
      end else if (out_valid && out_ready) begin
        if (out_last) begin
          state <= IDLE;
          out_valid <= 1'b0;
          out_last <= 1'b0;
        end else begin
          idx <= idx_nxt;
          out_data <= shadow[idx_nxt];
          out_last <= idx_nxt == IDX_LAST;
        end
      end
    end
  end
endmodule

// File: tb/tb_pulse_correlator_core.sv
// tb_pulse_correlator_core: table-driven frame vectors plus directed timing, backpressure, overrun, reset and enable sequences
module tb_pulse_correlator_core;
  localparam int N = 3;
  localparam int R = 8;
  localparam int FW = 12;
  typedef logic [0:FW-1][R-1:0] frame_t;
  typedef struct packed {
    logic [0:7][N-1:0] pat;
    frame_t exp;
    logic aux;
  } vec_t;
  logic clki = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b1;
  logic out_ready = 1'b1;
  logic [N-1:0] pulse_in = '0;
  logic [N-1:0] pulse_inv;
  logic scp, icp, out_valid, out_last, overrun;
  logic [R-1:0] out_data;
  logic i_scp, i_icp, i_valid, i_last, i_ovr;
  logic [R-1:0] i_data;
  logic s_scp, s_icp, s_valid, s_last, s_ovr;
  logic [2:0] s_data;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;
  vec_t vecs [3];
  frame_t f1, f8;
  assign pulse_inv = ~pulse_in;
  always #5 clki = ~clki;
  always @(posedge clki) cyc++;
  pulse_correlator_core #(.NUM_INPUTS(N), .RESOLUTION(R), .MAX_DELAY(1), .SAMPLE_DIV(4),
    .INTEG_SAMPLES(8), .INVERT_MASK(3'b000)) dut (
    .clki(clki), .rstn(rstn), .enable(enable), .pulse_in(pulse_in),
    .sample_clk_pulse(scp), .integration_clk_pulse(icp), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last), .overrun(overrun));
  pulse_correlator_core #(.NUM_INPUTS(N), .RESOLUTION(R), .MAX_DELAY(1), .SAMPLE_DIV(4),
    .INTEG_SAMPLES(8), .INVERT_MASK(3'b111)) dut_inv (
    .clki(clki), .rstn(rstn), .enable(enable), .pulse_in(pulse_inv),
    .sample_clk_pulse(i_scp), .integration_clk_pulse(i_icp), .out_data(i_data),
    .out_valid(i_valid), .out_ready(out_ready), .out_last(i_last), .overrun(i_ovr));
  pulse_correlator_core #(.NUM_INPUTS(N), .RESOLUTION(3), .MAX_DELAY(1), .SAMPLE_DIV(4),
    .INTEG_SAMPLES(8), .INVERT_MASK(3'b000)) dut_sat (
    .clki(clki), .rstn(rstn), .enable(enable), .pulse_in(pulse_in),
    .sample_clk_pulse(s_scp), .integration_clk_pulse(s_icp), .out_data(s_data),
    .out_valid(s_valid), .out_ready(out_ready), .out_last(s_last), .overrun(s_ovr));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  task automatic start(input logic [N-1:0] p);
    rstn = 1'b0;
    pulse_in = p;
    enable = 1'b1;
    out_ready = 1'b1;
    repeat (2) @(negedge clki);
    rstn = 1'b1;
    c0 = cyc;
  endtask
  task automatic wait_scp();
    int t = 0;
    @(negedge clki);
    while (!scp && t < 50) begin
      @(negedge clki);
      t++;
    end
    chk("scp_seen", 32'(scp), 1);
  endtask
  task automatic wait_icp();
    int t = 0;
    while (!icp && t < 200) begin
      @(negedge clki);
      t++;
    end
    chk("icp_seen", 32'(icp), 1);
  endtask
  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clki);
      t++;
    end
    chk("valid_seen", 32'(out_valid), 1);
  endtask
  task automatic read_frame(input string tag, input frame_t e, input logic aux);
    out_ready = 1'b1;
    wait_valid();
    for (int w = 0; w < FW; w++) begin
      chk($sformatf("%s_w%0d", tag, w), 32'(out_data), 32'(e[w]));
      chk($sformatf("%s_last%0d", tag, w), 32'(out_last), 32'(w == FW - 1));
      if (aux) begin
        chk($sformatf("%s_inv_w%0d", tag, w), 32'(i_data), 32'(e[w]));
        chk($sformatf("%s_sat_w%0d", tag, w), 32'(s_data), 7);
        chk($sformatf("%s_aux_ctl%0d", tag, w), 32'({i_valid, s_valid, i_last, s_last}),
            32'({2'b11, {2{w == FW - 1}}}));
      end
      @(negedge clki);
    end
    chk({tag, "_idle"}, 32'(out_valid), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end
  initial begin
    int first_sc, sc_n, ic_n, ic1, ic2, aux_sc, aux_ic, ov_n, t;
    f1 = {8'd8, 8'd8, 8'd8, 8'd7, 8'd8, 8'd7, 8'd7, 8'd8, 8'd7, 8'd7, 8'd8, 8'd7};
    f8 = {FW{8'd8}};
    vecs[0].pat = {8{3'b111}};
    vecs[0].exp = f1;
    vecs[0].aux = 1'b1;
    vecs[1].pat = {3'b000, 3'b000, 3'b001, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[1].exp = {8'd1, 8'd1, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    vecs[1].aux = 1'b0;
    vecs[2].pat = {4{3'b101, 3'b001}};
    vecs[2].exp = {8'd8, 8'd0, 8'd4, 8'd0, 8'd0, 8'd0, 8'd3, 8'd4, 8'd4, 8'd0, 8'd0, 8'd0};
    vecs[2].aux = 1'b0;
    for (int v = 0; v < 3; v++) begin
      start(vecs[v].pat[0]);
      for (int n = 1; n < 8; n++) begin
        wait_scp();
        pulse_in = vecs[v].pat[n];
      end
      wait_scp();
      pulse_in = '0;
      read_frame($sformatf("vec%0d", v), vecs[v].exp, vecs[v].aux);
    end
    start(3'b111);
    chk("reset_outputs", 32'({scp, icp, out_valid, out_last, overrun}), 0);
    chk("reset_data", 32'(out_data), 0);
    first_sc = -1;
    sc_n = 0;
    ic_n = 0;
    ic1 = 0;
    ic2 = 0;
    aux_sc = 0;
    aux_ic = 0;
    ov_n = 0;
    repeat (70) begin
      @(negedge clki);
      if (scp) begin
        if (sc_n == 0) first_sc = cyc - c0;
        sc_n++;
      end
      if (icp) begin
        if (ic_n == 0) ic1 = cyc - c0;
        else ic2 = cyc - c0;
        ic_n++;
      end
      if (i_scp && s_scp) aux_sc++;
      if (i_icp && s_icp) aux_ic++;
      if (overrun || i_ovr || s_ovr) ov_n++;
    end
    chk("first_sample_cycle", first_sc, 4);
    chk("sample_count", sc_n, 17);
    chk("integ1_cycle", ic1, 33);
    chk("integ2_cycle", ic2, 65);
    chk("integ_count", ic_n, 2);
    chk("aux_sample_count", aux_sc, 17);
    chk("aux_integ_count", aux_ic, 2);
    chk("no_overrun", ov_n, 0);
    start(3'b111);
    wait_valid();
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("bp_w%0d", w), 32'(out_data), 32'(f1[w]));
      @(negedge clki);
    end
    out_ready = 1'b0;
    ov_n = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clki);
      chk($sformatf("stall_data%0d", k), 32'(out_data), 32'(f1[4]));
      chk($sformatf("stall_valid%0d", k), 32'(out_valid), 1);
      if (overrun) ov_n++;
    end
    t = 0;
    while (!overrun && t < 100) begin
      @(negedge clki);
      t++;
    end
    chk("overrun_seen", 32'(overrun), 1);
    chk("overrun_icp", 32'(icp), 1);
    ov_n += 32'(overrun);
    repeat (5) begin
      @(negedge clki);
      if (overrun) ov_n++;
    end
    chk("overrun_once", ov_n, 1);
    chk("held_after_overrun", 32'(out_data), 32'(f1[4]));
    out_ready = 1'b1;
    for (int w = 4; w < FW; w++) begin
      chk($sformatf("resume_w%0d", w), 32'(out_data), 32'(f1[w]));
      chk($sformatf("resume_last%0d", w), 32'(out_last), 32'(w == FW - 1));
      @(negedge clki);
    end
    chk("resume_idle", 32'(out_valid), 0);
    read_frame("after_overrun", f8, 1'b0);
    start(3'b111);
    wait_valid();
    for (int w = 0; w < 5; w++) @(negedge clki);
    chk("pre_reset_w5", 32'(out_data), 32'(f1[5]));
    rstn = 1'b0;
    @(negedge clki);
    chk("midframe_reset_ctl", 32'({scp, icp, out_valid, out_last, overrun}), 0);
    chk("midframe_reset_data", 32'(out_data), 0);
    rstn = 1'b1;
    c0 = cyc;
    wait_icp();
    chk("restart_cycle", cyc - c0, 33);
    read_frame("restart", f1, 1'b1);
    start(3'b111);
    repeat (10) @(negedge clki);
    enable = 1'b0;
    sc_n = 0;
    repeat (20) begin
      @(negedge clki);
      if (scp) sc_n++;
    end
    enable = 1'b1;
    chk("frozen_samples", sc_n, 0);
    wait_icp();
    chk("stretched_window", cyc - c0, 53);
    read_frame("enable", f1, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
